wave_pwm_dac: RTL and testbench

WAVE_PWM_DAC -- requirements
Module: wave_pwm_dac

---
 rtl/wave_pwm_dac.sv | 170 +++++++++++++++++
 tb/tb_wave_pwm_dac.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_pwm_dac.sv
// -----------------------------------------------------------------------------
// wave_pwm_dac
//
// Turns an 8-bit waveform sample into a PWM bit stream. A two-stage pipeline
// applies a Q1.7 gain and a signed DC offset, then saturates to 0..255. A
// frame engine plays one saturated value per 256-step PWM frame, where each
// step lasts PRESCALE clocks. The played duty only changes at a frame
// boundary, so the output never carries a partially updated frame.
//
// Parameters
//   PRESCALE     clk cycles per PWM count step (1..65535)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   enable       1 = run PWM, 0 = idle (output low, duty/clip held)
//   sample_in    unsigned waveform sample
//   gain         unsigned gain, Q1.7 (128 = 1.0)
//   offset       signed DC offset in LSBs
//   pwm_out      PWM output bit
//   frame_start  one-clk pulse on the first clock of every frame
//   duty_out     duty value played in the current frame
//   clip         current frame's duty was saturated
// -----------------------------------------------------------------------------
module wave_pwm_dac #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] sample_in,
  input  logic [7:0] gain,
  input  logic [7:0] offset,
  output logic       pwm_out,
  output logic       frame_start,
  output logic [7:0] duty_out,
  output logic       clip
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  // ---------------------------------------------------------------------------
  // Stage 1: gain multiply and Q1.7 rescale. The offset travels with the
  // sample so both reach stage 2 from the same input clock.
  // ---------------------------------------------------------------------------
  logic [15:0] prod_d;
  logic [8:0]  scaled_d;
  logic [8:0]  scaled_q;
  logic [7:0]  offset_q;

  assign prod_d   = sample_in * gain;
  assign scaled_d = 9'(prod_d >> 7);

  // NOTE: pipeline registers are reset along with the control state so the
  // first frame after reset plays a well-defined duty of 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scaled_q <= '0;
      offset_q <= '0;
    end else begin
      // NOTE: sequential state is always assigned with <= so every register
      // samples the pre-edge values of the others.
      scaled_q <= scaled_d;
      offset_q <= offset;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: add signed offset and saturate to the 8-bit duty range.
  // ---------------------------------------------------------------------------
  logic signed [10:0] sum_d;
  logic [7:0]         cand_d;
  logic               cand_clip_d;
  logic [7:0]         cand_q;
  logic               cand_clip_q;

  assign sum_d = $signed({2'b00, scaled_q}) + $signed({{3{offset_q[7]}}, offset_q});

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    cand_d      = sum_d[7:0];
    cand_clip_d = 1'b0;
    if (sum_d < 11'sd0) begin
      cand_d      = 8'h00;
      cand_clip_d = 1'b1;
    end else if (sum_d > 11'sd255) begin
      cand_d      = 8'hFF;
      cand_clip_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q      <= '0;
      cand_clip_q <= 1'b0;
    end else begin
      cand_q      <= cand_d;
      cand_clip_q <= cand_clip_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame engine: IDLE/RUN FSM with prescaler and 8-bit PWM counter.
  // ---------------------------------------------------------------------------
  state_e      state_q;
  logic [15:0] pre_cnt_q;
  logic [7:0]  pwm_cnt_q;
  logic [7:0]  duty_q;
  logic        clip_q;
  logic        frame_start_q;
  logic        tick;

  assign tick = (pre_cnt_q == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pre_cnt_q     <= '0;
      pwm_cnt_q     <= '0;
      duty_q        <= '0;
      clip_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          pre_cnt_q <= '0;
          pwm_cnt_q <= '0;
          if (enable) begin
            // Fresh frame: counters already at 0, latch the new duty.
            state_q       <= RUN;
            duty_q        <= cand_q;
            clip_q        <= cand_clip_q;
            frame_start_q <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            // Dropping enable discards the partial frame entirely.
            state_q   <= IDLE;
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
          end else if (tick) begin
            pre_cnt_q <= '0;
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            if (pwm_cnt_q == 8'hFF) begin
              duty_q        <= cand_q;
              clip_q        <= cand_clip_q;
              frame_start_q <= 1'b1;
            end
          end else begin
            pre_cnt_q <= pre_cnt_q + 16'd1;
          end
        end
      endcase
    end
  end

  // Decoded purely from registers; goes low immediately on reset or IDLE.
  assign pwm_out     = (state_q == RUN) && (pwm_cnt_q < duty_q);
  assign frame_start = frame_start_q;
  assign duty_out    = duty_q;
  assign clip        = clip_q;

endmodule

// File: tb/tb_wave_pwm_dac.sv
// -----------------------------------------------------------------------------
// tb_wave_pwm_dac
//
// Drives two instances (PRESCALE=1 and PRESCALE=4) from shared inputs. A
// behavioural model tracks, per instance, whether a frame is running and how
// many clocks have elapsed since its start; the expected output is then plain
// arithmetic (high while elapsed < duty*PRESCALE). Scenario tasks add
// targeted checks on frame length, high time, clipping and reset behaviour.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wave_pwm_dac;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] sample_in;
  logic [7:0] gain;
  logic [7:0] offset;

  logic       pwm_o  [2];
  logic       fs_o   [2];
  logic [7:0] duty_o [2];
  logic       clip_o [2];

  int errors = 0;
  int checks = 0;
  int mon_prints = 0;
  bit mon_on = 1'b0;

  always #5 clk = ~clk;

  wave_pwm_dac #(.PRESCALE(1)) dut_p1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in),
    .gain(gain), .offset(offset), .pwm_out(pwm_o[0]), .frame_start(fs_o[0]),
    .duty_out(duty_o[0]), .clip(clip_o[0])
  );

  wave_pwm_dac #(.PRESCALE(4)) dut_p4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in),
    .gain(gain), .offset(offset), .pwm_out(pwm_o[1]), .frame_start(fs_o[1]),
    .duty_out(duty_o[1]), .clip(clip_o[1])
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int pfac(input int inst);
    return (inst == 0) ? 1 : 4;
  endfunction

  // {clip, duty} from plain integer arithmetic.
  function automatic logic [8:0] exp_cand(input int s, input int g, input int o);
    int v;
    v = (s * g) / 128 + o;
    if (v < 0)   return {1'b1, 8'd0};
    if (v > 255) return {1'b1, 8'd255};
    return {1'b0, 8'(v)};
  endfunction

  logic [8:0] hist[$];   // candidates computed from past inputs, oldest first
  bit         m_run  [2];
  int         m_k    [2]; // clocks elapsed in the current frame
  logic [7:0] m_duty [2];
  bit         m_clip [2];
  bit         m_fs   [2];

  function automatic bit exp_pwm(input int inst);
    return m_run[inst] && (m_k[inst] < int'(m_duty[inst]) * pfac(inst));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [8:0] ld;
    if (!rst_n) begin
      hist = {};
      hist.push_back(9'd0);
      hist.push_back(9'd0);
      for (int i = 0; i < 2; i++) begin
        m_run[i] = 1'b0; m_k[i] = 0; m_duty[i] = 8'd0; m_clip[i] = 1'b0; m_fs[i] = 1'b0;
      end
    end else begin
      // The value offered at this edge was computed from inputs two edges ago.
      ld = hist.pop_front();
      hist.push_back(exp_cand(int'(sample_in), int'(gain), int'($signed(offset))));
      for (int i = 0; i < 2; i++) begin
        m_fs[i] = 1'b0;
        if (!m_run[i]) begin
          if (enable) begin
            m_run[i] = 1'b1; m_k[i] = 0; m_duty[i] = ld[7:0]; m_clip[i] = ld[8]; m_fs[i] = 1'b1;
          end
        end else if (!enable) begin
          m_run[i] = 1'b0; m_k[i] = 0;
        end else begin
          m_k[i] = m_k[i] + 1;
          if (m_k[i] == 256 * pfac(i)) begin
            m_k[i] = 0; m_duty[i] = ld[7:0]; m_clip[i] = ld[8]; m_fs[i] = 1'b1;
          end
        end
      end
    end
  end

  // Cycle-by-cycle scoreboard against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_on) begin
      for (int i = 0; i < 2; i++) begin
        logic [10:0] obs, expv;
        obs  = {pwm_o[i], fs_o[i], clip_o[i], duty_o[i]};
        expv = {exp_pwm(i), m_fs[i], m_clip[i], m_duty[i]};
        checks++;
        if (obs !== expv) begin
          errors++;
          if (mon_prints < 20) begin
            mon_prints++;
            $display("FAIL model_cmp inst=%0d t=%0t got{pwm,fs,clip,duty}=%h expected=%h",
                     i, $time, obs, expv);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers (stimulus / bounded waits)
  // ---------------------------------------------------------------------------
  task automatic set_inputs(input int s, input int g, input int o);
    sample_in = 8'(s);
    gain      = 8'(g);
    offset    = 8'(o);
  endtask

  // Wait for a frame start on instance inst that plays the given duty.
  task automatic wait_frame(input int inst, input int duty, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (fs_o[inst] === 1'b1 && duty_o[inst] === 8'(duty)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    set_inputs(0, 128, 0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({pwm_o[i], fs_o[i], clip_o[i], duty_o[i]} !== 11'd0) begin
        errors++;
        $display("FAIL reset_state inst=%0d got=%h expected=000", i,
                 {pwm_o[i], fs_o[i], clip_o[i], duty_o[i]});
      end
    end
    rst_n  = 1'b1;
    mon_on = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    int high, fsn;
    set_inputs(100, 128, 0);
    enable = 1'b1;
    wait_frame(0, 100, 800, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_frame_wait got=timeout expected=duty 100"); end
    checks++;
    if (clip_o[0] !== 1'b0) begin errors++; $display("FAIL basic_clip got=%b expected=0", clip_o[0]); end
    high = 0; fsn = 0;
    for (int c = 0; c < 256; c++) begin
      high += int'(pwm_o[0]);
      fsn  += int'(fs_o[0]);
      @(negedge clk);
    end
    checks++;
    if (high != 100) begin errors++; $display("FAIL basic_high_time got=%0d expected=100", high); end
    checks++;
    if (fsn != 1) begin errors++; $display("FAIL basic_fs_count got=%0d expected=1", fsn); end
    checks++;
    if (fs_o[0] !== 1'b1) begin errors++; $display("FAIL basic_frame_len got=fs %b at 256 expected=1", fs_o[0]); end
  endtask

  task automatic test_clip_high();
    bit ok;
    int high;
    set_inputs(255, 255, 0);
    wait_frame(0, 255, 800, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clip_hi_wait got=timeout expected=duty 255"); end
    checks++;
    if (dut_p1.scaled_q !== 9'd508) begin
      errors++; $display("FAIL clip_hi_scaled got=%0d expected=508", dut_p1.scaled_q);
    end
    checks++;
    if (clip_o[0] !== 1'b1) begin errors++; $display("FAIL clip_hi_flag got=%b expected=1", clip_o[0]); end
    high = 0;
    for (int c = 0; c < 256; c++) begin
      high += int'(pwm_o[0]);
      @(negedge clk);
    end
    checks++;
    if (high != 255) begin errors++; $display("FAIL clip_hi_high_time got=%0d expected=255", high); end
  endtask

  task automatic test_clip_low();
    bit ok;
    int high;
    set_inputs(64, 128, 8'h80);
    wait_frame(0, 0, 800, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clip_lo_wait got=timeout expected=duty 0"); end
    checks++;
    if (clip_o[0] !== 1'b1) begin errors++; $display("FAIL clip_lo_flag got=%b expected=1", clip_o[0]); end
    high = 0;
    for (int c = 0; c < 256; c++) begin
      high += int'(pwm_o[0]);
      @(negedge clk);
    end
    checks++;
    if (high != 0) begin errors++; $display("FAIL clip_lo_high_time got=%0d expected=0", high); end
  endtask

  task automatic test_midframe();
    bit ok;
    int high;
    set_inputs(50, 128, 0);
    wait_frame(1, 50, 2600, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_wait got=timeout expected=duty 50"); end
    high = 0;
    for (int c = 0; c < 1024; c++) begin
      high += int'(pwm_o[1]);
      if (c == 300) sample_in = 8'd200;
      @(negedge clk);
    end
    checks++;
    if (high != 200) begin errors++; $display("FAIL mid_cur_frame got=%0d expected=200", high); end
    checks++;
    if (fs_o[1] !== 1'b1 || duty_o[1] !== 8'd200) begin
      errors++; $display("FAIL mid_next_start got=fs %b duty %0d expected=fs 1 duty 200", fs_o[1], duty_o[1]);
    end
    high = 0;
    for (int c = 0; c < 1024; c++) begin
      high += int'(pwm_o[1]);
      @(negedge clk);
    end
    checks++;
    if (high != 800) begin errors++; $display("FAIL mid_next_frame got=%0d expected=800", high); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    set_inputs(100, 128, 0);
    wait_frame(0, 100, 800, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL drop_wait got=timeout expected=duty 100"); end
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (m_run[0] && m_k[0] == 37) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL drop_cnt37 got=timeout expected=count 37"); end
    checks++;
    if (dut_p1.pwm_cnt_q !== 8'd37) begin
      errors++; $display("FAIL drop_at37 got=%0d expected=37", dut_p1.pwm_cnt_q);
    end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (pwm_o[0] !== 1'b0 || dut_p1.pwm_cnt_q !== 8'd0 || duty_o[0] !== 8'd100) begin
      errors++;
      $display("FAIL drop_idle got=pwm %b cnt %0d duty %0d expected=pwm 0 cnt 0 duty 100",
               pwm_o[0], dut_p1.pwm_cnt_q, duty_o[0]);
    end
    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (fs_o[0] !== 1'b1 || pwm_o[0] !== 1'b1 || dut_p1.pwm_cnt_q !== 8'd0) begin
      errors++;
      $display("FAIL drop_restart got=fs %b pwm %b cnt %0d expected=fs 1 pwm 1 cnt 0",
               fs_o[0], pwm_o[0], dut_p1.pwm_cnt_q);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    set_inputs(180, 128, 0);
    wait_frame(0, 180, 800, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL arst_wait got=timeout expected=duty 180"); end
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({pwm_o[i], fs_o[i], clip_o[i], duty_o[i]} !== 11'd0) begin
        errors++;
        $display("FAIL arst_immediate inst=%0d got=%h expected=000", i,
                 {pwm_o[i], fs_o[i], clip_o[i], duty_o[i]});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (fs_o[0] !== 1'b0 || pwm_o[0] !== 1'b0) begin
      errors++; $display("FAIL arst_release got=fs %b pwm %b expected=0 0", fs_o[0], pwm_o[0]);
    end
    @(negedge clk);
    checks++;
    if (fs_o[0] !== 1'b1 || duty_o[0] !== 8'd0) begin
      errors++; $display("FAIL arst_resume got=fs %b duty %0d expected=fs 1 duty 0", fs_o[0], duty_o[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0)
        set_inputs($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      if ($urandom_range(0, 299) == 0) enable = ~enable;
    end
    enable = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip_high();
    test_clip_low();
    test_midframe();
    test_enable_drop();
    test_async_reset();
    test_random();
    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
